muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide engine beside the ALU in the multicycle core.
//   The control FSM pulses start with funct3 and the rs1/rs2 operands for OP_R_TYPE with funct7=0000001.
//   It then waits on done and writes result back through the ALU_WB path.
//   Shift-add multiply and restoring divide, one bit per cycle, on magnitudes, with a final sign-fix cycle.
// PARAMETERS
//   WIDTH   32   operand/result width; even, >=8; iteration count = WIDTH
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-low reset
//   start    in   1      request; accepted only in IDLE or DONE
//   funct3   in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   a        in   WIDTH  rs1 operand; sampled on the accepting edge only
//   b        in   WIDTH  rs2 operand; sampled on the accepting edge only
//   busy     out  1      high in CALC and FIX
//   done     out  1      one-cycle pulse; result valid
//   result   out  WIDTH  registered; held until the next accepted start
// BEHAVIOUR
//   Reset (rst=0, any time, including mid-operation):
//     - state=IDLE; busy=0, done=0, result=0, internal accumulators and counter cleared.
//   States: IDLE -> CALC -> FIX -> DONE -> IDLE. From DONE, a start is accepted directly into CALC.
//   Accept: start=1 in IDLE/DONE latches funct3, |a|, |b|, the result sign and the op class. Counter=0.
//     - Signedness: MUL/MULH/DIV/REM treat a and b as signed.
//     - MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: both unsigned.
//   CALC: WIDTH cycles, counter 0..WIDTH-1. Leave CALC when counter==WIDTH-1.
//     - mul: 2*WIDTH-bit product accumulator; add the shifted multiplicand when the multiplier LSB=1.
//     - div: restoring shift/subtract; quotient bit=1 when the trial remainder is >=0.
//   FIX: one cycle. Negate the product if signs differ (two's complement over 2*WIDTH bits).
//     - Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
//     - Loads result: MUL=low half; MULH*=high half; DIV*=quotient; REM*=remainder.
//   DONE: done=1 and busy=0 for exactly one cycle; result stable.
//   Latency: start accepted at edge E0 -> CALC for E1..EWIDTH, FIX at EWIDTH+1, done high after EWIDTH+2.
//     - WIDTH=32: done is high in the 34th cycle after the accepting edge.
//   Special cases skip CALC/FIX: accept -> DONE on the next edge, so done is high in cycle 1.
//     - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = a.
//     - Signed overflow (a=100..0, b=all ones): DIV result = a; REM result = 0.
//   Boundaries:
//     - start while busy=1 is ignored; no queueing, and operands are not resampled.
//     - start=1 in DONE: the done pulse still completes; the new op enters CALC on that edge.
//     - funct3 and a/b changing after acceptance have no effect.
//     - A product of 0 is never negated into a nonzero value (0 stays 0).
// CONFIGURATION
//   MULDIV_SINGLE_CYCLE_MUL_EN
//     - Defined: MUL/MULH/MULHSU/MULHU use a combinational signed 2*WIDTH multiply at acceptance.
//       Accept -> DONE on the next edge (1-cycle latency); CALC/FIX are used only by divides.
//     - Undefined: all multiplies are iterative (WIDTH+2 latency); no '*' operator is inferred.
//     - Divide behaviour is identical in both builds.
// TESTING
//   MUL a=7, b=0xFFFFFFFD -> result=0xFFFFFFEB; done in cycle 34 (cycle 1 with MULDIV_SINGLE_CYCLE_MUL_EN).
//   MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
//   DIV a=0xFFFFFFF9(-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//   DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
//   Start DIVU 100/7; re-pulse start with other operands in cycle 5 -> ignored, result=14.
//     - Start a new op in the DONE cycle -> the second result is correct with full latency.
//   Start MUL, drop rst at cycle 10 -> busy=0, done=0, result=0 immediately.
//     - After release, a fresh MUL 3*4 -> 12 with nominal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply, restoring divide, sign-fix cycle.
// Optional MULDIV_SINGLE_CYCLE_MUL_EN: multiplies complete combinationally at acceptance.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    p;
  logic [WIDTH-1:0] dsr;
  logic [2:0]       op;
  logic             neg_q, neg_r;

  logic             accept, is_div, a_signed, b_signed, a_neg, b_neg;
  logic             div_zero, div_ovf, fast, div_ge;
  logic [WIDTH-1:0] abs_a, abs_b, fast_res, div_diff, quo_fix, rem_fix, fix_res;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [PW-1:0]    p_nx, prod_fix;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  logic signed [WIDTH:0]  ma, mb;
  logic signed [PW-1:0]   mp;
`endif

  // Operand decode and early-exit detection at acceptance.
  always_comb begin
    accept   = start && (state == S_IDLE || state == S_DONE);
    is_div   = funct3[2];
    a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    b_signed = a_signed && (funct3 != 3'b010);
    a_neg    = a_signed && a[WIDTH-1];
    b_neg    = b_signed && b[WIDTH-1];
    abs_a    = a_neg ? (~a + WIDTH'(1)) : a;
    abs_b    = b_neg ? (~b + WIDTH'(1)) : b;
    div_zero = (b == '0);
    div_ovf  = a_signed && b_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    fast     = is_div && (div_zero || div_ovf);
    if (div_zero) fast_res = funct3[1] ? a : '1;
    else          fast_res = funct3[1] ? '0 : a;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    ma = {a_neg, a};
    mb = {b_neg, b};
    mp = PW'(ma) * PW'(mb);
    if (!is_div) begin
      fast     = 1'b1;
      fast_res = (funct3 == 3'b000) ? mp[WIDTH-1:0] : mp[PW-1:WIDTH];
    end
`endif
  end

  // One iteration step plus the sign-fixed result selection.
  always_comb begin
    mul_sum   = {1'b0, p[PW-1:WIDTH]} + (p[0] ? {1'b0, dsr} : '0);
    div_shift = {p[PW-1:WIDTH], p[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, dsr});
    div_diff  = div_shift[WIDTH-1:0] - dsr;
    if (!op[2])      p_nx = {mul_sum, p[WIDTH-1:1]};
    else if (div_ge) p_nx = {div_diff, p[WIDTH-2:0], 1'b1};
    else             p_nx = {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    prod_fix = neg_q ? (~p + PW'(1)) : p;
    quo_fix  = neg_q ? (~p[WIDTH-1:0] + WIDTH'(1)) : p[WIDTH-1:0];
    rem_fix  = neg_r ? (~p[PW-1:WIDTH] + WIDTH'(1)) : p[PW-1:WIDTH];
    if (op == 3'b000) fix_res = prod_fix[WIDTH-1:0];
    else if (!op[2])  fix_res = prod_fix[PW-1:WIDTH];
    else if (op[1])   fix_res = rem_fix;
    else              fix_res = quo_fix;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = fast ? S_DONE : S_CALC;
      S_CALC: if (cnt == CW'(WIDTH - 1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: begin
        state_nx = S_IDLE;
        if (accept) state_nx = fast ? S_DONE : S_CALC;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      p      <= '0;
      dsr    <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (accept) begin
        op    <= funct3;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        cnt   <= '0;
        p     <= {{WIDTH{1'b0}}, abs_a};
        dsr   <= abs_b;
        if (fast) result <= fast_res;
      end else if (state == S_CALC) begin
        p   <= p_nx;
        cnt <= cnt + CW'(1);
      end else if (state == S_FIX) begin
        result <= fix_res;
      end
      busy <= (state_nx == S_CALC) || (state_nx == S_FIX);
      done <= (state_nx == S_DONE);
    end
  end

endmodule
